// File: rtl/bus_node.sv
// Shared-bus endpoint: decodes controller headers, times the grant window
// before the named source may drive, and buffers beats addressed here.
module bus_node #(
    parameter int              DATA_W     = 8,
    parameter int              ID_W       = 2,
    parameter logic [ID_W-1:0] CTRL_ID    = {ID_W{1'b1}},
    parameter int              GRANT_WAIT = 3,
    parameter int              RX_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ID_W-1:0]   node_id,
    input  logic              send_valid,
    input  logic [DATA_W-1:0] send_data,
    output logic              send_ready,
    input  logic              ack,
    output logic              recv_valid,
    output logic [DATA_W-1:0] recv_data,
    input  logic              recv_ready,
    output logic              rx_overflow,
    output logic              proto_err,
    inout  wire  [DATA_W-1:0] bus_data,
    inout  wire               bus_valid
);
    localparam int          AW   = $clog2(RX_DEPTH);
    localparam logic [3:0]  GW   = GRANT_WAIT[3:0];
    localparam logic [AW:0] FULL = RX_DEPTH[AW:0];

    typedef enum logic [1:0] {IDLE, HDR, GRANT, XFER} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ID_W-1:0]   src_q, src_d, dst_q, dst_d;
    logic              perr_q, perr_d;
    logic [DATA_W-1:0] mem_q [RX_DEPTH];
    logic [DATA_W-1:0] mem_d [RX_DEPTH];
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]       occ_q, occ_d;
    logic              ovf_q, ovf_d;

    logic              bv, drive_en, push, pop, full, do_push;
    logic [ID_W-1:0]   hdr_src, hdr_dst, m_src, m_dst;
    logic [3:0]        cnt_inc;

    assign bv      = bus_valid;
    assign hdr_src = bus_data[2+ID_W-1:2];
    assign hdr_dst = bus_data[2+2*ID_W-1:2+ID_W];
    assign cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            perr_q  <= perr_d;
        end
    end

    // Next state: the counter runs from header capture, so a long HDR phase
    // eats into the grant window rather than extending it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        dst_d   = dst_q;
        perr_d  = perr_q | (state_q == GRANT && bv);
        if (ack) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (bv) begin
                    state_d = HDR;
                    cnt_d   = 4'd1;
                    src_d   = hdr_src;
                    dst_d   = hdr_dst;
                end
                HDR: begin
                    cnt_d = cnt_inc;
                    if (!bv) state_d = GRANT;
                end
                GRANT: begin
                    if (cnt_q >= GW) state_d = XFER;
                    else             cnt_d   = cnt_inc;
                end
                default: ;
            endcase
        end
    end

    // Outputs: bus ownership is gated by reset and ack so release is immediate
    always_comb begin
        drive_en = 1'b0;
        if (rst_n && !ack) begin
            case (state_q)
                IDLE, HDR: drive_en = (node_id == CTRL_ID) && send_valid;
                XFER:      drive_en = (node_id == src_q) && send_valid;
                default:   drive_en = 1'b0;
            endcase
        end
    end

    assign send_ready = drive_en;
    assign bus_data   = drive_en ? send_data : {DATA_W{1'bz}};
    assign bus_valid  = drive_en ? 1'b1 : 1'bz;

    assign m_src   = (state_q == IDLE) ? hdr_src : src_q;
    assign m_dst   = (state_q == IDLE) ? hdr_dst : dst_q;
    assign push    = bv && !drive_en &&
                     (node_id == m_src || node_id == m_dst || node_id == CTRL_ID);
    assign full    = (occ_q == FULL);
    assign pop     = recv_valid && recv_ready;
    assign do_push = push && (!full || pop);

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        occ_d = occ_q;
        ovf_d = ovf_q | (push && full && !pop);
        if (do_push) begin
            mem_d[wr_q] = bus_data;
            wr_d        = wr_q + 1'b1;
        end
        if (pop) rd_d = rd_q + 1'b1;
        case ({do_push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RX_DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            occ_q <= occ_d;
            ovf_q <= ovf_d;
        end
    end

    assign recv_valid  = (occ_q != '0);
    assign recv_data   = recv_valid ? mem_q[rd_q] : '0;
    assign rx_overflow = ovf_q;
    assign proto_err   = perr_q;

endmodule

// File: tb/tb_bus_node.sv
// Four bus_node instances (IDs 0..3, controller = 3) on one shared bus with
// a weak pull-down; per-node scoreboard queues hold the beats each should buffer.
module tb_bus_node;
    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       ack      = 1'b0;
    logic       ext_en   = 1'b0;
    logic [7:0] ext_data = 8'h00;
    logic       sv   [4];
    logic [7:0] sd   [4];
    logic       rr   [4];
    logic       sr   [4];
    logic       rv   [4];
    logic [7:0] rdat [4];
    logic       ovf  [4];
    logic       perr [4];
    wire  [7:0] bus_data;
    wire        bus_valid;
    logic [7:0] sb [4][$];
    logic [7:0] beats [4];
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    assign bus_data  = ext_en ? ext_data : 8'bz;
    assign bus_valid = ext_en ? 1'b1 : 1'bz;
    pulldown (bus_valid);
    for (genvar b = 0; b < 8; b++) begin : g_pd
        pulldown (bus_data[b]);
    end

    for (genvar i = 0; i < 4; i++) begin : g_node
        bus_node #(.DATA_W(8), .ID_W(2), .CTRL_ID(2'd3), .GRANT_WAIT(3), .RX_DEPTH(4)) u_dut (
            .clk(clk), .rst_n(rst_n), .node_id(2'(i)),
            .send_valid(sv[i]), .send_data(sd[i]), .send_ready(sr[i]),
            .ack(ack),
            .recv_valid(rv[i]), .recv_data(rdat[i]), .recv_ready(rr[i]),
            .rx_overflow(ovf[i]), .proto_err(perr[i]),
            .bus_data(bus_data), .bus_valid(bus_valid)
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rx(input int n, input logic [7:0] d);
        sb[n].push_back(d);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_bv"}, 32'(bus_valid), 32'd0);
        chk({tag, "_bus"}, 32'(bus_data), 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_sr%0d", tag, k), 32'(sr[k]), 32'd0);
            chk($sformatf("%s_rv%0d", tag, k), 32'(rv[k]), 32'd0);
            chk($sformatf("%s_rdat%0d", tag, k), 32'(rdat[k]), 32'd0);
            chk($sformatf("%s_ovf%0d", tag, k), 32'(ovf[k]), 32'd0);
            chk($sformatf("%s_perr%0d", tag, k), 32'(perr[k]), 32'd0);
        end
    endtask

    // Pops node n's FIFO until its scoreboard is exhausted, then expects empty
    task automatic drain(input int n);
        logic [7:0] e;
        rr[n] = 1'b1;
        while (sb[n].size() > 0) begin
            #1;
            e = sb[n].pop_front();
            chk($sformatf("rx%0d_valid", n), 32'(rv[n]), 32'd1);
            chk($sformatf("rx%0d_data", n), 32'(rdat[n]), 32'(e));
            step();
        end
        rr[n] = 1'b0;
        #1;
        chk($sformatf("rx%0d_empty", n), 32'(rv[n]), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 4; k++) begin
            sv[k] = 1'b0; sd[k] = 8'h00; rr[k] = 1'b0;
        end
        beats[0] = 8'h14; beats[1] = 8'h21; beats[2] = 8'h32; beats[3] = 8'h43;

        // Reset: controller requesting to send must still see a released bus
        sv[3] = 1'b1; sd[3] = 8'h18;
        #1 rst_n = 1'b0;
        #2;
        chk_idle("rst");
        sv[3] = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();

        // Header dst=1 src=2, grant window, node 2 transfer
        sv[3] = 1'b1; sd[3] = 8'h18; #1;
        chk("hdr_sr3", 32'(sr[3]), 32'd1);
        chk("hdr_bus", 32'(bus_data), 32'h18);
        chk("hdr_bv", 32'(bus_valid), 32'd1);
        expect_rx(1, 8'h18); expect_rx(2, 8'h18);
        step();
        sv[3] = 1'b0; sv[2] = 1'b1; sd[2] = 8'hA5; #1;
        chk("hdr2_sr2", 32'(sr[2]), 32'd0);
        step();
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("grant_sr2", 32'(sr[2]), 32'd0);
            chk("grant_bv", 32'(bus_valid), 32'd0);
            step();
        end
        sv[1] = 1'b1; sd[1] = 8'h3C; #1;
        chk("xfer_sr2", 32'(sr[2]), 32'd1);
        chk("xfer_bus", 32'(bus_data), 32'hA5);
        chk("xfer_bv", 32'(bus_valid), 32'd1);
        chk("xfer_sr1", 32'(sr[1]), 32'd0);
        expect_rx(1, 8'hA5); expect_rx(3, 8'hA5);
        step();
        sv[1] = 1'b0; sv[2] = 1'b0; #1;
        chk("n0_empty", 32'(rv[0]), 32'd0);
        drain(1); drain(2); drain(3);
        ack = 1'b1; step(); ack = 1'b0;

        // Overflow: header src=dst=1 plus command beats into node 1
        sv[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sd[3] = beats[i];
            expect_rx(1, beats[i]);
            step();
        end
        #1;
        chk("full_ovf", 32'(ovf[1]), 32'd0);
        chk("full_rv", 32'(rv[1]), 32'd1);
        sd[3] = 8'h54; rr[1] = 1'b1; #1;
        chk("pp_head", 32'(rdat[1]), 32'(sb[1].pop_front()));
        expect_rx(1, 8'h54);
        step();
        rr[1] = 1'b0; #1;
        chk("pp_no_ovf", 32'(ovf[1]), 32'd0);
        sd[3] = 8'h65;
        step();
        sv[3] = 1'b0; #1;
        chk("ovf_set", 32'(ovf[1]), 32'd1);
        drain(1);
        ack = 1'b1; step(); ack = 1'b0;
        step(); #1;
        chk("ovf_sticky", 32'(ovf[1]), 32'd1);

        // ack collides with a header: no capture, re-sent header times the grant
        ext_data = 8'h18; ext_en = 1'b1; ack = 1'b1;
        sv[3] = 1'b1; sd[3] = 8'h18; #1;
        chk("ack_sr3", 32'(sr[3]), 32'd0);
        expect_rx(1, 8'h18); expect_rx(2, 8'h18); expect_rx(3, 8'h18);
        step();
        ext_en = 1'b0; ack = 1'b0; #1;
        chk("resend_sr3", 32'(sr[3]), 32'd1);
        expect_rx(1, 8'h18); expect_rx(2, 8'h18);
        step();
        sv[3] = 1'b0; sv[2] = 1'b1; sd[2] = 8'h5A;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("ack_grant_sr2", 32'(sr[2]), 32'd0);
            step();
        end
        #1;
        chk("ack_xfer_sr2", 32'(sr[2]), 32'd1);
        chk("ack_xfer_bus", 32'(bus_data), 32'h5A);

        // Reset mid-transfer releases the bus without waiting for an edge
        #1 rst_n = 1'b0;
        #1;
        chk_idle("mid_rst");
        for (int k = 0; k < 4; k++) sb[k].delete();
        sv[2] = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();

        // Foreign bus_valid during GRANT
        sv[3] = 1'b1; sd[3] = 8'h18;
        expect_rx(1, 8'h18); expect_rx(2, 8'h18);
        step();
        sv[3] = 1'b0;
        step();
        ext_data = 8'h77; ext_en = 1'b1; #1;
        chk("perr_pre", 32'(perr[1]), 32'd0);
        expect_rx(1, 8'h77); expect_rx(2, 8'h77); expect_rx(3, 8'h77);
        step();
        ext_en = 1'b0; #1;
        for (int k = 0; k < 4; k++) chk($sformatf("perr_set%0d", k), 32'(perr[k]), 32'd1);
        ack = 1'b1; step(); ack = 1'b0;
        step(); step(); #1;
        for (int k = 0; k < 4; k++) chk($sformatf("perr_sticky%0d", k), 32'(perr[k]), 32'd1);
        drain(1); drain(2); drain(3);
        rst_n = 1'b0; #1;
        chk("perr_rst", 32'(perr[1]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
